// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: sequencer states,
// register specifier width, the zero register and a saturating counter helper.
package mips_pkg;

    localparam int REG_W = 5;

    // Register $zero is hard-wired, so a load targeting it never creates a dependency.
    localparam int ZERO_REG = 0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hazard_state_e;

    function automatic logic [15:0] satInc(input logic [15:0] value, input logic en);
        satInc = (en && (value != 16'hFFFF)) ? value + 16'd1 : value;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard sequencer (slave).
// The statistics counters appear only when HAZARD_STATS_EN is defined.
interface hazard_ctrl_if #(
    parameter int REG_W = mips_pkg::REG_W
);
    logic             IDEX_MemRead;
    logic [REG_W-1:0] IDEX_Rt;
    logic [REG_W-1:0] IFID_Rs;
    logic [REG_W-1:0] IFID_Rt;
    logic             BranchTaken;
    logic             MemReq;
    logic             MemReady;

    logic             PCWrite;
    logic             IFIDWrite;
    logic             IDEXWrite;
    logic             EXMEMWrite;
    logic             CtrlBubble;
    logic             IFIDFlush;
    logic             IDEXFlush;
    logic             EXMEMFlush;
    logic             PCSrc;
    logic             MemTimeout;
`ifdef HAZARD_STATS_EN
    logic [15:0]      StallCount;
    logic [15:0]      FlushCount;
    logic [15:0]      WaitCount;
`endif

    modport master (
        output IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, BranchTaken, MemReq, MemReady,
        input  PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, CtrlBubble,
        input  IFIDFlush, IDEXFlush, EXMEMFlush, PCSrc, MemTimeout
`ifdef HAZARD_STATS_EN
        , input StallCount, FlushCount, WaitCount
`endif
    );

    modport slave (
        input  IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, BranchTaken, MemReq, MemReady,
        output PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, CtrlBubble,
        output IFIDFlush, IDEXFlush, EXMEMFlush, PCSrc, MemTimeout
`ifdef HAZARD_STATS_EN
        , output StallCount, FlushCount, WaitCount
`endif
    );

endinterface

// File: rtl/hazard_ctrl_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a load in EX
// is about to write.
module hazard_detect #(
    parameter int REG_W = mips_pkg::REG_W
) (
    input  logic             idexMemRead_i,
    input  logic [REG_W-1:0] idexRt_i,
    input  logic [REG_W-1:0] ifidRs_i,
    input  logic [REG_W-1:0] ifidRt_i,
    output logic             loadUse_o
);
    import mips_pkg::*;

    logic rtIsZero;
    logic rsMatch;
    logic rtMatch;

    assign rtIsZero  = (idexRt_i == REG_W'(ZERO_REG));
    assign rsMatch   = (idexRt_i == ifidRs_i);
    assign rtMatch   = (idexRt_i == ifidRt_i);
    assign loadUse_o = idexMemRead_i && !rtIsZero && (rsMatch || rtMatch);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use bubbles, taken-branch flushes and memory-wait freeze with
// a timeout watchdog. Define HAZARD_STATS_EN to add saturating event counters.
module hazard_ctrl #(
    parameter int REG_W       = mips_pkg::REG_W,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  hz
);
    import mips_pkg::*;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

    hazard_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic loadUse;
    logic memStall;
    logic stallEvt;
    logic flushEvt;
    logic waitEvt;

    logic pcWrite, ifidWrite, idexWrite, exmemWrite;
    logic ctrlBubble, ifidFlush, idexFlush, exmemFlush;
    logic pcSrc, memTimeout;

    hazard_detect #(
        .REG_W (REG_W)
    ) u_detect (
        .idexMemRead_i (hz.IDEX_MemRead),
        .idexRt_i      (hz.IDEX_Rt),
        .ifidRs_i      (hz.IFID_Rs),
        .ifidRt_i      (hz.IFID_Rt),
        .loadUse_o     (loadUse)
    );

    assign memStall = hz.MemReq && !hz.MemReady;

    // Outputs are Mealy; reset overrides them directly so they respond without a clock edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pcWrite    = 1'b1;
        ifidWrite  = 1'b1;
        idexWrite  = 1'b1;
        exmemWrite = 1'b1;
        ctrlBubble = 1'b0;
        ifidFlush  = 1'b0;
        idexFlush  = 1'b0;
        exmemFlush = 1'b0;
        pcSrc      = 1'b0;
        memTimeout = 1'b0;
        stallEvt   = 1'b0;
        flushEvt   = 1'b0;
        waitEvt    = 1'b0;

        if (!rst_n) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexWrite  = 1'b0;
            exmemWrite = 1'b0;
            ctrlBubble = 1'b1;
            ifidFlush  = 1'b1;
            idexFlush  = 1'b1;
            exmemFlush = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (memStall) begin
                        pcWrite    = 1'b0;
                        ifidWrite  = 1'b0;
                        idexWrite  = 1'b0;
                        exmemWrite = 1'b0;
                        state_d    = MEM_WAIT;
                        cnt_d      = CNT_W'(1);
                    end else if (hz.BranchTaken) begin
                        pcSrc      = 1'b1;
                        ifidFlush  = 1'b1;
                        idexFlush  = 1'b1;
                        exmemFlush = 1'b1;
                        flushEvt   = 1'b1;
                    end else if (loadUse) begin
                        pcWrite    = 1'b0;
                        ifidWrite  = 1'b0;
                        ctrlBubble = 1'b1;
                        stallEvt   = 1'b1;
                    end
                end
                // Frozen stages hold their inputs, so branch and load-use are not re-evaluated here.
                MEM_WAIT: begin
                    waitEvt = 1'b1;
                    if (hz.MemReady) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        pcWrite    = 1'b0;
                        ifidWrite  = 1'b0;
                        idexWrite  = 1'b0;
                        exmemWrite = 1'b0;
                        if (cnt_q == TIMEOUT_CNT) begin
                            state_d = ERROR;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ERROR: begin
                    pcWrite    = 1'b0;
                    ifidWrite  = 1'b0;
                    idexWrite  = 1'b0;
                    exmemWrite = 1'b0;
                    memTimeout = 1'b1;
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz.PCWrite    = pcWrite;
    assign hz.IFIDWrite  = ifidWrite;
    assign hz.IDEXWrite  = idexWrite;
    assign hz.EXMEMWrite = exmemWrite;
    assign hz.CtrlBubble = ctrlBubble;
    assign hz.IFIDFlush  = ifidFlush;
    assign hz.IDEXFlush  = idexFlush;
    assign hz.EXMEMFlush = exmemFlush;
    assign hz.PCSrc      = pcSrc;
    assign hz.MemTimeout = memTimeout;

`ifdef HAZARD_STATS_EN
    logic [15:0] stallCnt_q;
    logic [15:0] flushCnt_q;
    logic [15:0] waitCnt_q;

    // Event strobes are never raised in ERROR, so the counters freeze there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt_q <= '0;
            flushCnt_q <= '0;
            waitCnt_q  <= '0;
        end else begin
            stallCnt_q <= satInc(stallCnt_q, stallEvt);
            flushCnt_q <= satInc(flushCnt_q, flushEvt);
            waitCnt_q  <= satInc(waitCnt_q, waitEvt);
        end
    end

    assign hz.StallCount = stallCnt_q;
    assign hz.FlushCount = flushCnt_q;
    assign hz.WaitCount  = waitCnt_q;
`else
    logic unusedEvents;
    assign unusedEvents = stallEvt ^ flushEvt ^ waitEvt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed hazard scenarios followed by random traffic,
// each cycle checked against a cycle-level behavioural model of the sequencer rules.
module tb_hazard_ctrl;

    localparam int REG_W       = 5;
    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 5;

    typedef struct packed {
        logic        pcWrite;
        logic        ifidWrite;
        logic        idexWrite;
        logic        exmemWrite;
        logic        ctrlBubble;
        logic        ifidFlush;
        logic        idexFlush;
        logic        exmemFlush;
        logic        pcSrc;
        logic        memTimeout;
`ifdef HAZARD_STATS_EN
        logic [15:0] stallCount;
        logic [15:0] flushCount;
        logic [15:0] waitCount;
`endif
    } outs_t;

    typedef struct {
        outs_t o;
        string tag;
    } exp_t;

    logic clk;
    logic rst_n;

    hazard_ctrl_if #(.REG_W(REG_W)) hzBus ();

    hazard_ctrl #(
        .REG_W       (REG_W),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hzBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    exp_t expQ[$];

    // Reference model: whether the pipeline is dead, and how many frozen cycles so far.
    bit errored   = 0;
    int waitSoFar = 0;
    int stallN    = 0;
    int flushN    = 0;
    int waitN     = 0;

    function automatic outs_t sampleOutputs();
        outs_t s;
        s.pcWrite    = hzBus.PCWrite;
        s.ifidWrite  = hzBus.IFIDWrite;
        s.idexWrite  = hzBus.IDEXWrite;
        s.exmemWrite = hzBus.EXMEMWrite;
        s.ctrlBubble = hzBus.CtrlBubble;
        s.ifidFlush  = hzBus.IFIDFlush;
        s.idexFlush  = hzBus.IDEXFlush;
        s.exmemFlush = hzBus.EXMEMFlush;
        s.pcSrc      = hzBus.PCSrc;
        s.memTimeout = hzBus.MemTimeout;
`ifdef HAZARD_STATS_EN
        s.stallCount = hzBus.StallCount;
        s.flushCount = hzBus.FlushCount;
        s.waitCount  = hzBus.WaitCount;
`endif
        return s;
    endfunction

    function automatic outs_t forcedReset();
        outs_t e;
        e = '0;
        e.ctrlBubble = 1'b1;
        e.ifidFlush  = 1'b1;
        e.idexFlush  = 1'b1;
        e.exmemFlush = 1'b1;
        return e;
    endfunction

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic checkOutput(input string name, input outs_t got, input outs_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    task automatic modelReset();
        errored   = 0;
        waitSoFar = 0;
        stallN    = 0;
        flushN    = 0;
        waitN     = 0;
    endtask

    // Drives one cycle of inputs just after a rising edge and queues the expected outputs.
    task automatic applyStimulus(input bit rstN, input bit memRead, input int idexRt,
                                 input int rs, input int rt, input bit br,
                                 input bit req, input bit rdy, input string tag);
        exp_t  x;
        outs_t e;
        bit    loadUse;

        rst_n              = rstN;
        hzBus.IDEX_MemRead = memRead;
        hzBus.IDEX_Rt      = REG_W'(idexRt);
        hzBus.IFID_Rs      = REG_W'(rs);
        hzBus.IFID_Rt      = REG_W'(rt);
        hzBus.BranchTaken  = br;
        hzBus.MemReq       = req;
        hzBus.MemReady     = rdy;

        loadUse = memRead && (idexRt != 0) && (idexRt == rs || idexRt == rt);

        e = '0;
        e.pcWrite    = 1'b1;
        e.ifidWrite  = 1'b1;
        e.idexWrite  = 1'b1;
        e.exmemWrite = 1'b1;
`ifdef HAZARD_STATS_EN
        e.stallCount = 16'(stallN);
        e.flushCount = 16'(flushN);
        e.waitCount  = 16'(waitN);
`endif

        if (!rstN) begin
            e = forcedReset();
            modelReset();
        end else if (errored) begin
            {e.pcWrite, e.ifidWrite, e.idexWrite, e.exmemWrite} = 4'b0000;
            e.memTimeout = 1'b1;
        end else if (waitSoFar > 0) begin
            waitN = sat16(waitN + 1);
            if (rdy) begin
                waitSoFar = 0;
            end else begin
                {e.pcWrite, e.ifidWrite, e.idexWrite, e.exmemWrite} = 4'b0000;
                if (waitSoFar >= MEM_TIMEOUT) errored = 1;
                else waitSoFar++;
            end
        end else if (req && !rdy) begin
            {e.pcWrite, e.ifidWrite, e.idexWrite, e.exmemWrite} = 4'b0000;
            waitSoFar = 1;
        end else if (br) begin
            e.pcSrc      = 1'b1;
            e.ifidFlush  = 1'b1;
            e.idexFlush  = 1'b1;
            e.exmemFlush = 1'b1;
            flushN = sat16(flushN + 1);
        end else if (loadUse) begin
            e.pcWrite    = 1'b0;
            e.ifidWrite  = 1'b0;
            e.ctrlBubble = 1'b1;
            stallN = sat16(stallN + 1);
        end

        x.o   = e;
        x.tag = tag;
        expQ.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    // Drops reset in the middle of a cycle and checks the outputs respond without a clock.
    task automatic asyncResetCheck(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput(tag, sampleOutputs(), forcedReset());
        modelReset();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t item;
        if (expQ.size() > 0) begin
            item = expQ.pop_front();
            checkOutput(item.tag, sampleOutputs(), item.o);
        end
    end

    initial begin
        int drain;
        rst_n              = 1'b0;
        hzBus.IDEX_MemRead = 1'b0;
        hzBus.IDEX_Rt      = '0;
        hzBus.IFID_Rs      = '0;
        hzBus.IFID_Rt      = '0;
        hzBus.BranchTaken  = 1'b0;
        hzBus.MemReq       = 1'b0;
        hzBus.MemReady     = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, "reset_hold");
        applyStimulus(0, 1, 8, 8, 0, 1, 1, 0, "reset_hold_busy");
        idle(2, "after_reset_idle");

        applyStimulus(1, 1, 8, 8, 3, 0, 0, 0, "loaduse_rs");
        applyStimulus(1, 0, 8, 8, 3, 0, 0, 0, "loaduse_cleared");
        applyStimulus(1, 1, 9, 2, 9, 0, 0, 0, "loaduse_rt");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, "loaduse_zero_reg");
        applyStimulus(1, 1, 8, 8, 0, 1, 0, 0, "branch_over_loaduse");
        applyStimulus(1, 1, 8, 8, 0, 0, 1, 1, "single_cycle_mem");

        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 8, 8, 0, 1, 1, 0, "mem_wait3");
        applyStimulus(1, 1, 8, 8, 0, 1, 1, 1, "mem_wait3_ready");
        idle(1, "after_wait_idle");

        for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, "pre_async_wait");
        asyncResetCheck("async_reset_mid_wait");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, "reset_after_wait");
        idle(1, "release_after_wait");

        for (int i = 0; i <= MEM_TIMEOUT; i++) applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, "timeout_run");
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, "timeout_flag");
        applyStimulus(1, 1, 8, 8, 0, 1, 1, 1, "timeout_sticky");
        idle(2, "timeout_sticky_idle");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, "timeout_reset");
        idle(1, "timeout_cleared");

        for (int i = 0; i < MEM_TIMEOUT; i++) applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, "boundary_wait");
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, "boundary_ready");
        idle(2, "boundary_after");

        for (int i = 0; i < 600; i++) begin
            bit rn, mr, br, rq, rd;
            rn = ($urandom_range(0, 99) >= 2);
            mr = ($urandom_range(0, 1) == 1);
            br = ($urandom_range(0, 4) == 0);
            rq = ($urandom_range(0, 2) == 0);
            rd = ($urandom_range(0, 3) != 0);
            if (i >= 300 && i < 330) rd = 1'b0;
            applyStimulus(rn, mr, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), br, rq, rd, "random");
        end

        drain = 0;
        while (expQ.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        if (expQ.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain pending=%0d want=0", expQ.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
